// File: rtl/coin_input_conditioner.sv
// Coin/button front end: 2-flop sync, per-line debounce, press queueing and
// a fixed-priority serializer that emits one-hot, one-cycle pulses.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20,
    parameter int GAP             = 1
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw_q,
    input  logic raw_d,
    input  logic raw_n,
    input  logic raw_soda,
    input  logic raw_diet,
    output logic Q,
    output logic D,
    output logic N,
    output logic soda,
    output logic diet,
    output logic busy,
    output logic overrun
);

    localparam int NCH   = 5;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    // Channel index order is also the priority order: Q, D, N, soda, diet.
    logic [NCH-1:0]   raw_v;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   pulse;
    logic [CNT_W-1:0] cnt [NCH];
    logic [GAP_W-1:0] gap_cnt;

    logic [NCH-1:0]   press;
    logic [NCH-1:0]   grant;
    logic [NCH-1:0]   clr;
    logic             issue;
    logic             found;

    assign raw_v = {raw_diet, raw_soda, raw_n, raw_d, raw_q};

    always_comb begin
        press = '0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // A press is the edge where a debounced line flips from 0 to 1.
            press[i] = s2[i] && !stable[i] &&
                       (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
            if (pending[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        issue = (gap_cnt == '0) && found;
        clr   = issue ? grant : '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            stable  <= '0;
            pending <= '0;
            pulse   <= '0;
            gap_cnt <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw_v;
            s2 <= s1;
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end

            // A press landing on its own issue edge survives as a new pending event.
            pending <= (pending & ~clr) | press;
            if (|(press & pending & ~clr)) begin
                overrun <= 1'b1;
            end

            pulse <= clr;
            if (issue) begin
                gap_cnt <= GAP_W'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    assign Q    = pulse[0];
    assign D    = pulse[1];
    assign N    = pulse[2];
    assign soda = pulse[3];
    assign diet = pulse[4];
    assign busy = (|pending) || (gap_cnt != '0);

endmodule
